// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder, one full-adder cell, LSB first.
// A+B+CarryIn takes WIDTH cycles in RUN, then a one-cycle DONE.
// Optional build macro SERIAL_ADDER_SUB_EN adds a Sub input (A-B as A+~B+1).
module serial_adder_ctrl #(
   parameter int unsigned WIDTH = 64
) (
   input  logic             Clock,
   input  logic             ResetN,
   input  logic             Start,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             Sub,
`endif
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             CarryIn,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Sum,
   output logic             CarryOut,
   output logic             Overflow
);

   localparam int unsigned CntW = $clog2(WIDTH);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e state_q, state_d;

   logic [WIDTH-1:0] a_q, b_q;
   logic [WIDTH-2:0] sh_q;       // low sum bits collected so far, MSB-aligned
   logic [CntW-1:0]  cnt_q;
   logic             carry_q;
   logic             b_inv;
   logic             accept;
   logic             last_step;
   logic             fa_a, fa_b, fa_s, fa_c;
   logic [WIDTH-1:0] sh_ext;

   assign accept    = Start && !Busy;
   assign last_step = (state_q == StRun) && (cnt_q == CntW'(WIDTH - 1));

`ifdef SERIAL_ADDER_SUB_EN
   logic sub_q;

   // Sub is captured with the operands so it cannot change mid-operation
   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         sub_q <= 1'b0;
      end else if (accept) begin
         sub_q <= Sub;
      end
   end

   assign b_inv = sub_q;
`else
   assign b_inv = 1'b0;
`endif

   // The single full-adder cell
   assign fa_a   = a_q[0];
   assign fa_b   = b_q[0] ^ b_inv;
   assign fa_s   = fa_a ^ fa_b ^ carry_q;
   assign fa_c   = (fa_a & fa_b) | (carry_q & (fa_a ^ fa_b));
   assign sh_ext = {fa_s, sh_q};

   // State register
   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (Start) state_d = StRun;
         StRun:   if (last_step) state_d = StDone;
         StDone:  state_d = Start ? StRun : StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Status outputs decoded from the state
   always_comb begin
      Busy = (state_q == StRun);
      Done = (state_q == StDone);
   end

   // Operand capture, bit-serial datapath and result registers
   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         a_q      <= '0;
         b_q      <= '0;
         sh_q     <= '0;
         cnt_q    <= '0;
         carry_q  <= 1'b0;
         Sum      <= '0;
         CarryOut <= 1'b0;
         Overflow <= 1'b0;
      end else if (accept) begin
         a_q   <= A;
         b_q   <= B;
         sh_q  <= '0;
         cnt_q <= '0;
`ifdef SERIAL_ADDER_SUB_EN
         carry_q <= Sub ? 1'b1 : CarryIn;
`else
         carry_q <= CarryIn;
`endif
      end else if (state_q == StRun) begin
         a_q     <= a_q >> 1;
         b_q     <= b_q >> 1;
         sh_q    <= sh_ext[WIDTH-1:1];
         carry_q <= fa_c;
         cnt_q   <= cnt_q + CntW'(1);
         if (last_step) begin
            Sum      <= sh_ext;
            CarryOut <= fa_c;
            // carry_q is the carry into the MSB at this step
            Overflow <= carry_q ^ fa_c;
         end
      end
   end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: a 64-bit and an 8-bit instance.
// Define SERIAL_ADDER_SUB_EN to also exercise subtraction on the 8-bit one.
module tb_serial_adder_ctrl;

   typedef struct {
      logic [63:0] sum;
      logic        cout;
      logic        ovf;
      int          cyc;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int n_vec = 0;
   int n_err = 0;
   int ndone8 = 0;
   int ndone64 = 0;

   exp_t q64[$];
   exp_t q8[$];

   // 64-bit instance
   logic        rst64 = 1'b0, start64 = 1'b0, cin64 = 1'b0, sub64 = 1'b0;
   logic [63:0] a64 = '0, b64 = '0, sum64;
   logic        busy64, done64, cout64, ovf64;

   // 8-bit instance
   logic        rst8 = 1'b0, start8 = 1'b0, cin8 = 1'b0, sub8 = 1'b0;
   logic [7:0]  a8 = '0, b8 = '0, sum8;
   logic        busy8, done8, cout8, ovf8;

   serial_adder_ctrl dut64 (
      .Clock(clk), .ResetN(rst64), .Start(start64),
`ifdef SERIAL_ADDER_SUB_EN
      .Sub(sub64),
`endif
      .A(a64), .B(b64), .CarryIn(cin64),
      .Busy(busy64), .Done(done64), .Sum(sum64), .CarryOut(cout64), .Overflow(ovf64)
   );

   serial_adder_ctrl #(.WIDTH(8)) dut8 (
      .Clock(clk), .ResetN(rst8), .Start(start8),
`ifdef SERIAL_ADDER_SUB_EN
      .Sub(sub8),
`endif
      .A(a8), .B(b8), .CarryIn(cin8),
      .Busy(busy8), .Done(done8), .Sum(sum8), .CarryOut(cout8), .Overflow(ovf8)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitors: pop and compare whenever Done is seen
   always @(negedge clk) begin
      if (done64) begin
         ndone64++;
         if (q64.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL dut64 spurious Done: got Done=1, required 0 (cycle %0d)", cyc);
         end else begin
            exp_t e;
            e = q64.pop_front();
            check("dut64 Sum", sum64, e.sum);
            check("dut64 CarryOut", {63'b0, cout64}, {63'b0, e.cout});
            check("dut64 Overflow", {63'b0, ovf64}, {63'b0, e.ovf});
            check("dut64 Done cycle", 64'(cyc), 64'(e.cyc));
         end
      end
   end

   always @(negedge clk) begin
      if (done8) begin
         ndone8++;
         if (q8.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL dut8 spurious Done: got Done=1, required 0 (cycle %0d)", cyc);
         end else begin
            exp_t e;
            e = q8.pop_front();
            check("dut8 Sum", {56'b0, sum8}, e.sum);
            check("dut8 CarryOut", {63'b0, cout8}, {63'b0, e.cout});
            check("dut8 Overflow", {63'b0, ovf8}, {63'b0, e.ovf});
            check("dut8 Done cycle", 64'(cyc), 64'(e.cyc));
         end
      end
   end

   task automatic wait_cyc(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic drain64(input int budget);
      int n = 0;
      while (q64.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("dut64 scoreboard drained", 64'(q64.size()), 64'd0);
   endtask

   task automatic drain8(input int budget);
      int n = 0;
      while (q8.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("dut8 scoreboard drained", 64'(q8.size()), 64'd0);
   endtask

   // One isolated 8-bit operation, started at the next edge
   task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic ci, input logic sb,
                      input logic [7:0] es, input logic ec, input logic eo);
      @(negedge clk);
      a8 = a; b8 = b; cin8 = ci; sub8 = sb; start8 = 1'b1;
      q8.push_back('{sum: {56'b0, es}, cout: ec, ovf: eo, cyc: cyc + 1 + 8});
      @(negedge clk);
      start8 = 1'b0;
      drain8(30);
   endtask

   task automatic op64(input logic [63:0] a, input logic [63:0] b, input logic ci,
                       input logic [63:0] es, input logic ec, input logic eo);
      @(negedge clk);
      a64 = a; b64 = b; cin64 = ci; start64 = 1'b1;
      q64.push_back('{sum: es, cout: ec, ovf: eo, cyc: cyc + 1 + 64});
      @(negedge clk);
      start64 = 1'b0;
      drain64(100);
   endtask

   initial begin
      int k;
      int d;

      // Reset state, while ResetN is low
      start64 = 1'b1;
      start8  = 1'b1;
      repeat (3) @(negedge clk);
      check("reset busy64", {63'b0, busy64}, 64'd0);
      check("reset done64", {63'b0, done64}, 64'd0);
      check("reset sum64", sum64, 64'd0);
      check("reset busy8", {63'b0, busy8}, 64'd0);
      check("reset sum8/cout8/ovf8", {54'b0, sum8, cout8, ovf8}, 64'd0);
      start64 = 1'b0;
      start8  = 1'b0;
      rst8 = 1'b1;

      // Test 1: release reset and start together; Start must be taken at the first edge
      a64 = 64'd1; b64 = 64'd1; cin64 = 1'b1; start64 = 1'b1; rst64 = 1'b1;
      q64.push_back('{sum: 64'd3, cout: 1'b0, ovf: 1'b0, cyc: cyc + 1 + 64});
      @(negedge clk);
      start64 = 1'b0;
      check("dut64 Busy after first edge", {63'b0, busy64}, 64'd1);
      drain64(100);

      // Test 2 and a signed-overflow case at 64 bits
      op64(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 1'b1, 1'b0);
      op64(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);

      // Test 3: 0x7F+1, with an ignored Start at k+3 and altered operands
      d = ndone8;
      @(negedge clk);
      a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
      k = cyc + 1;
      q8.push_back('{sum: 64'h80, cout: 1'b0, ovf: 1'b1, cyc: k + 8});
      @(negedge clk);
      start8 = 1'b0;
      a8 = 8'h10; b8 = 8'h22;
      check("dut8 Busy after accept", {63'b0, busy8}, 64'd1);
      wait_cyc(k + 2);
      start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      drain8(30);
      repeat (12) @(negedge clk);
      check("dut8 single Done for test 3", 64'(ndone8 - d), 64'd1);

      // More directed 8-bit vectors
      op8(8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0);
      op8(8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
      op8(8'h7F, 8'h7F, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b1);

      // Test 4: reset at edge k+4 aborts; no Done afterwards
      op8(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
      @(negedge clk);
      a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
      k = cyc + 1;
      @(negedge clk);
      start8 = 1'b0;
      wait_cyc(k + 3);
      @(posedge clk);
      #1 rst8 = 1'b0;
      #1;
      check("abort Busy", {63'b0, busy8}, 64'd0);
      check("abort Sum", {56'b0, sum8}, 64'd0);
      check("abort Overflow", {63'b0, ovf8}, 64'd0);
      @(negedge clk);
      rst8 = 1'b1;
      d = ndone8;
      repeat (20) @(negedge clk);
      check("no Done after abort", 64'(ndone8 - d), 64'd0);

      // Test 5: Start held high, operands disturbed during RUN
      @(negedge clk);
      a8 = 8'd5; b8 = 8'd6; cin8 = 1'b0; start8 = 1'b1;
      k = cyc + 1;
      for (int i = 0; i < 3; i++)
         q8.push_back('{sum: 64'd11, cout: 1'b0, ovf: 1'b0, cyc: k + 8 + 9 * i});
      for (int i = 0; i < 3; i++) begin
         wait_cyc(k + 9 * i + 2);
         a8 = 8'd200; b8 = 8'd100; cin8 = 1'b1;
         wait_cyc(k + 9 * i + 7);
         a8 = 8'd5; b8 = 8'd6; cin8 = 1'b0;
      end
      wait_cyc(k + 26);
      start8 = 1'b0;
      drain8(30);
      repeat (12) @(negedge clk);
      check("dut8 idle after held Start", {63'b0, busy8}, 64'd0);

`ifdef SERIAL_ADDER_SUB_EN
      // Test 6: subtraction, CarryIn ignored
      op8(8'd5, 8'd7, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
      op8(8'd7, 8'd5, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0);
      op8(8'd5, 8'd7, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
`endif

      repeat (5) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Global time bound
   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete, required completion");
      $fatal(1, "timeout");
   end

endmodule
